// File: rtl/iterative_shifter.sv
// Multi-cycle RV64 shift unit (SLL/SRL/SRA and W-forms), shifting up to STEP bits per cycle.
// Operands and result each move over a valid/ready handshake; the result is held until consumed.
module iterative_shifter #(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_operand,
    input  logic [5:0]  in_shamt,
    input  logic [1:0]  in_op,
    input  logic        in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic        out_illegal
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned CW   = 7;
    localparam logic [CW-1:0] STEP_C = CW'(STEP);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [1:0]      op_q, op_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    logic [CW-1:0]   amt;
    logic [XLEN-1:0] load_val;
    logic [CW-1:0]   step_k;
    logic [CW-1:0]   count_next;
    logic [XLEN-1:0] shifted;

    // W-forms report the low word sign-extended to 64 bits.
    function automatic logic [XLEN-1:0] finalize(input logic [XLEN-1:0] v, input logic w);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    assign in_ready    = (state_q == S_IDLE) && rst_n;
    assign out_valid   = (state_q == S_DONE);
    assign out_result  = result_q;
    assign out_illegal = illegal_q;

    // Accept-side operand preparation and one shift step of the working register.
    always_comb begin
        amt        = in_word ? {2'b00, in_shamt[4:0]} : {1'b0, in_shamt};
        load_val   = in_operand;
        if (in_word) begin
            load_val = (in_op == OP_SRA) ? {{32{in_operand[31]}}, in_operand[31:0]}
                                         : {32'h0, in_operand[31:0]};
        end
        step_k     = (count_q < STEP_C) ? count_q : STEP_C;
        count_next = count_q - step_k;
        case (op_q)
            OP_SLL:  shifted = work_q << step_k;
            OP_SRL:  shifted = work_q >> step_k;
            default: shifted = $unsigned($signed(work_q) >>> step_k);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        work_d    = work_q;
        op_d      = op_q;
        word_d    = word_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d    = in_op;
                    word_d  = in_word;
                    work_d  = load_val;
                    count_d = amt;
                    if (in_op == OP_ILL) begin
                        result_d  = in_operand;
                        illegal_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (amt == '0) begin
                        result_d  = finalize(load_val, in_word);
                        illegal_d = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d  = shifted;
                count_d = count_next;
                if (count_next == '0) begin
                    result_d  = finalize(shifted, word_q);
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            work_q    <= '0;
            op_q      <= OP_SLL;
            word_q    <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            work_q    <= work_d;
            op_q      <= op_d;
            word_q    <= word_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter: STEP=1 and STEP=4 instances driven in lockstep.
module tb_iterative_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_operand;
    logic [5:0]  in_shamt;
    logic [1:0]  in_op;
    logic        in_word;
    logic        out_ready;

    logic        rdy1, rdy4, ov1, ov4, ill1, ill4;
    logic [63:0] res1, res4;

    int checks   = 0;
    int failures = 0;

    iterative_shifter #(.STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_operand(in_operand), .in_shamt(in_shamt), .in_op(in_op), .in_word(in_word),
        .out_valid(ov1), .out_ready(out_ready), .out_result(res1), .out_illegal(ill1)
    );

    iterative_shifter #(.STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
        .in_operand(in_operand), .in_shamt(in_shamt), .in_op(in_op), .in_word(in_word),
        .out_valid(ov4), .out_ready(out_ready), .out_result(res4), .out_illegal(ill4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] operand;
        logic [5:0]  shamt;
        logic [63:0] exp;
        logic        exp_ill;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input vec_t v, input int step);
        int n;
        n = v.word ? int'(v.shamt[4:0]) : int'(v.shamt);
        if (v.op == 2'b11 || n == 0) return 1;
        return (n + step - 1) / step + 1;
    endfunction

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (!(rdy1 && rdy4) && guard < 200) begin
            step_edge();
            guard++;
        end
        if (!(rdy1 && rdy4)) check({name, "_idle_timeout"}, 64'(guard), 64'd0);
    endtask

    // Accept one operation on both units and check result, flag and latency of each.
    task automatic run_op(input string name, input vec_t v);
        int lat1, lat4;
        logic [63:0] r1, r4;
        logic i1, i4, busy_rdy;
        wait_idle(name);
        in_valid   = 1'b1;
        in_op      = v.op;
        in_word    = v.word;
        in_operand = v.operand;
        in_shamt   = v.shamt;
        step_edge();
        in_valid   = 1'b0;
        in_operand = 64'hA5A5_A5A5_A5A5_A5A5;
        in_shamt   = 6'h2A;
        in_op      = 2'b01;
        in_word    = ~v.word;
        lat1 = -1; lat4 = -1; r1 = '0; r4 = '0; i1 = 1'b0; i4 = 1'b0; busy_rdy = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            if (lat1 < 0 && rdy1) busy_rdy = 1'b1;
            if (lat1 < 0 && ov1) begin lat1 = e; r1 = res1; i1 = ill1; end
            if (lat4 < 0 && ov4) begin lat4 = e; r4 = res4; i4 = ill4; end
            if (lat1 >= 0 && lat4 >= 0) break;
            step_edge();
        end
        check({name, "_res_s1"}, r1, v.exp);
        check({name, "_res_s4"}, r4, v.exp);
        check({name, "_ill_s1"}, 64'(i1), 64'(v.exp_ill));
        check({name, "_ill_s4"}, 64'(i4), 64'(v.exp_ill));
        check({name, "_lat_s1"}, 64'(lat1), 64'(exp_latency(v, 1)));
        check({name, "_lat_s4"}, 64'(lat4), 64'(exp_latency(v, 4)));
        check({name, "_rdy_low_s1"}, 64'(busy_rdy), 64'd0);
        step_edge();
    endtask

    initial begin
        vecs[0]  = '{2'b00, 1'b0, 64'h0000_0000_0000_0001, 6'd63, 64'h8000_0000_0000_0000, 1'b0};
        vecs[1]  = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 6'd6,  64'hFE00_0000_0000_0000, 1'b0};
        vecs[2]  = '{2'b10, 1'b1, 64'h1234_5678_8000_0000, 6'd33, 64'hFFFF_FFFF_C000_0000, 1'b0};
        vecs[3]  = '{2'b01, 1'b1, 64'h1234_5678_8000_0000, 6'd0,  64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[4]  = '{2'b00, 1'b1, 64'h0000_0000_4000_0001, 6'd1,  64'hFFFF_FFFF_8000_0002, 1'b0};
        vecs[5]  = '{2'b11, 1'b1, 64'h0000_0000_DEAD_BEEF, 6'd5,  64'h0000_0000_DEAD_BEEF, 1'b1};
        vecs[6]  = '{2'b01, 1'b0, 64'h0000_0000_0000_00F0, 6'd4,  64'h0000_0000_0000_000F, 1'b0};
        vecs[7]  = '{2'b11, 1'b1, 64'h1111_2222_DEAD_BEEF, 6'd9,  64'h1111_2222_DEAD_BEEF, 1'b1};
        vecs[8]  = '{2'b01, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 64'h0000_0000_0000_0001, 1'b0};
        vecs[9]  = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[10] = '{2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd31, 64'h0000_0000_0000_0001, 1'b0};
        vecs[11] = '{2'b10, 1'b1, 64'h0000_0000_7FFF_FFFF, 6'd4,  64'h0000_0000_07FF_FFFF, 1'b0};
        vecs[12] = '{2'b00, 1'b0, 64'h0000_0000_0000_0001, 6'd0,  64'h0000_0000_0000_0001, 1'b0};
        vecs[13] = '{2'b00, 1'b0, 64'h0000_0000_0000_1234, 6'd7,  64'h0000_0000_0009_1A00, 1'b0};
        vecs[14] = '{2'b00, 1'b1, 64'hFFFF_FFFF_0000_0001, 6'd63, 64'hFFFF_FFFF_8000_0000, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_operand = '0; in_shamt = '0;
        in_op = 2'b00; in_word = 1'b0; out_ready = 1'b1;
        step_edge();
        step_edge();
        check("rst_in_ready_s1", 64'(rdy1), 64'd0);
        check("rst_in_ready_s4", 64'(rdy4), 64'd0);
        check("rst_out_valid", 64'({ov1, ov4}), 64'd0);
        check("rst_out_result_s1", res1, 64'd0);
        check("rst_out_illegal", 64'({ill1, ill4}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'({rdy1, rdy4}), 64'd3);

        for (int i = 0; i < NV; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: result must hold and new requests must be ignored.
        wait_idle("bp");
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b01; in_word = 1'b0;
        in_operand = 64'h0000_0000_0000_00F0; in_shamt = 6'd4;
        step_edge();
        in_valid = 1'b0;
        for (int e = 0; e < 20 && !(ov1 && ov4); e++) step_edge();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                in_valid = 1'b1; in_op = 2'b00; in_operand = 64'h55; in_shamt = 6'd1;
            end else begin
                in_valid = 1'b0;
            end
            check($sformatf("bp_valid_c%0d", c), 64'({ov1, ov4}), 64'd3);
            check($sformatf("bp_res_s1_c%0d", c), res1, 64'h0F);
            check($sformatf("bp_res_s4_c%0d", c), res4, 64'h0F);
            check($sformatf("bp_ready_c%0d", c), 64'({rdy1, rdy4}), 64'd0);
            step_edge();
        end
        in_valid = 1'b0;
        check("bp_hold_after", res1, 64'h0F);
        out_ready = 1'b1;
        step_edge();
        check("bp_release_ready", 64'({rdy1, rdy4}), 64'd3);
        check("bp_release_valid", 64'({ov1, ov4}), 64'd0);

        // Reset in the middle of a long STEP=1 shift.
        wait_idle("rst_mid");
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b00; in_word = 1'b0;
        in_operand = 64'h1; in_shamt = 6'd40;
        step_edge();
        in_valid = 1'b0;
        for (int c = 1; c < 10; c++) step_edge();
        check("rst_mid_busy", 64'({ov1, rdy1}), 64'd0);
        rst_n = 1'b0;
        step_edge();
        check("rst_mid_valid", 64'({ov1, ov4}), 64'd0);
        check("rst_mid_res_s1", res1, 64'd0);
        check("rst_mid_res_s4", res4, 64'd0);
        check("rst_mid_ready_low", 64'({rdy1, rdy4}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_mid_ready_high", 64'({rdy1, rdy4}), 64'd3);
        out_ready = 1'b1;
        run_op("after_rst", '{2'b00, 1'b0, 64'h3, 6'd2, 64'hC, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
